// File: rtl/alu_mdu.sv
// Single-issue integer ALU with an iterative multiply/divide unit.
// Base ops finish in one cycle; MUL*/DIV*/REM* iterate one bit per cycle.
module alu_mdu #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_operandA,
    input  logic [XLEN-1:0] i_operandB,
    input  logic [4:0]      i_aluOp,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_aluData,
    output logic            o_busy
);

    localparam int SHW = $clog2(XLEN);
    localparam int CW  = $clog2(XLEN) + 1;

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_SLT    = 5'd2;
    localparam logic [4:0] OP_SLTU   = 5'd3;
    localparam logic [4:0] OP_XOR    = 5'd4;
    localparam logic [4:0] OP_OR     = 5'd5;
    localparam logic [4:0] OP_AND    = 5'd6;
    localparam logic [4:0] OP_SLL    = 5'd7;
    localparam logic [4:0] OP_SRL    = 5'd8;
    localparam logic [4:0] OP_SRA    = 5'd9;
    localparam logic [4:0] OP_LUI    = 5'd10;
    localparam logic [4:0] OP_MUL    = 5'd16;
    localparam logic [4:0] OP_MULH   = 5'd17;
    localparam logic [4:0] OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_MULHU  = 5'd19;
    localparam logic [4:0] OP_DIV    = 5'd20;
    localparam logic [4:0] OP_DIVU   = 5'd21;
    localparam logic [4:0] OP_REM    = 5'd22;
    localparam logic [4:0] OP_REMU   = 5'd23;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Everything the iterative unit needs to finish an op once operands are gone.
    typedef struct packed {
        logic isDiv;
        logic selRem;
        logic mulLow;
        logic negQ;
        logic negR;
    } ctx_t;

    state_t            state;
    ctx_t              ctx;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   opnd;
    logic [CW-1:0]     cnt;
    logic              validReg;
    logic [XLEN-1:0]   dataReg;

    logic              accept;
    logic              signA, signB, aNeg, bNeg, bZero, divOvf, isLong;
    logic [XLEN-1:0]   aMag, bMag, quickRes;
    logic [SHW-1:0]    shamt;

    assign o_ready   = (state == IDLE);
    assign o_busy    = (state == BUSY);
    assign o_valid   = validReg;
    assign o_aluData = dataReg;
    assign accept    = i_valid && o_ready && !i_flush;

    always_comb begin
        signA  = (i_aluOp == OP_MULH) || (i_aluOp == OP_MULHSU) ||
                 (i_aluOp == OP_DIV)  || (i_aluOp == OP_REM);
        signB  = (i_aluOp == OP_MULH) || (i_aluOp == OP_DIV) || (i_aluOp == OP_REM);
        aNeg   = signA & i_operandA[XLEN-1];
        bNeg   = signB & i_operandB[XLEN-1];
        aMag   = aNeg ? -i_operandA : i_operandA;
        bMag   = bNeg ? -i_operandB : i_operandB;
        bZero  = (i_operandB == '0);
        divOvf = (i_operandA == MOST_NEG) && (i_operandB == '1);
        shamt  = i_operandB[SHW-1:0];
        quickRes = '0;
        isLong   = 1'b0;
        case (i_aluOp)
            OP_ADD:  quickRes = i_operandA + i_operandB;
            OP_SUB:  quickRes = i_operandA - i_operandB;
            OP_SLT:  quickRes = {{(XLEN-1){1'b0}}, $signed(i_operandA) < $signed(i_operandB)};
            OP_SLTU: quickRes = {{(XLEN-1){1'b0}}, i_operandA < i_operandB};
            OP_XOR:  quickRes = i_operandA ^ i_operandB;
            OP_OR:   quickRes = i_operandA | i_operandB;
            OP_AND:  quickRes = i_operandA & i_operandB;
            OP_SLL:  quickRes = i_operandA << shamt;
            OP_SRL:  quickRes = i_operandA >> shamt;
            OP_SRA:  quickRes = $signed(i_operandA) >>> shamt;
            OP_LUI:  quickRes = i_operandB;
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: isLong = 1'b1;
            OP_DIV, OP_REM: begin
                // Zero divisor and MIN/-1 have fixed answers and skip iteration.
                if (bZero)       quickRes = (i_aluOp == OP_DIV) ? '1 : i_operandA;
                else if (divOvf) quickRes = (i_aluOp == OP_DIV) ? i_operandA : '0;
                else             isLong = 1'b1;
            end
            OP_DIVU, OP_REMU: begin
                if (bZero) quickRes = (i_aluOp == OP_DIVU) ? '1 : i_operandA;
                else       isLong = 1'b1;
            end
            default: quickRes = '0;
        endcase
    end

    // One iteration step: shift-add multiply or restoring divide on {hi, lo}.
    logic [XLEN:0]     mulSum, trial, diff;
    logic [2*XLEN-1:0] mulNext, divNext, prodNext, prodSigned;
    logic [XLEN-1:0]   quot, rem, finalRes;

    always_comb begin
        mulSum  = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, (prod[0] ? opnd : {XLEN{1'b0}})};
        mulNext = {mulSum, prod[XLEN-1:1]};
        trial   = prod[2*XLEN-1:XLEN-1];
        diff    = trial - {1'b0, opnd};
        divNext = {(diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0]), prod[XLEN-2:0], ~diff[XLEN]};
        prodNext   = ctx.isDiv ? divNext : mulNext;
        prodSigned = ctx.negQ ? -prodNext : prodNext;
        quot = prodNext[XLEN-1:0];
        rem  = prodNext[2*XLEN-1:XLEN];
        if (ctx.isDiv)
            finalRes = ctx.selRem ? (ctx.negR ? -rem : rem) : (ctx.negQ ? -quot : quot);
        else
            finalRes = ctx.mulLow ? prodSigned[XLEN-1:0] : prodSigned[2*XLEN-1:XLEN];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            ctx      <= '0;
            prod     <= '0;
            opnd     <= '0;
            cnt      <= '0;
            validReg <= 1'b0;
            dataReg  <= '0;
        end else if (i_flush) begin
            state    <= IDLE;
            validReg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (isLong) begin
                            state      <= BUSY;
                            cnt        <= '0;
                            ctx.isDiv  <= i_aluOp[2];
                            ctx.selRem <= i_aluOp[1];
                            ctx.mulLow <= (i_aluOp[1:0] == 2'b00);
                            ctx.negQ   <= aNeg ^ bNeg;
                            ctx.negR   <= aNeg;
                            // Multiply walks B through the low half; divide shifts A out of it.
                            prod <= {{XLEN{1'b0}}, (i_aluOp[2] ? aMag : bMag)};
                            opnd <= i_aluOp[2] ? bMag : aMag;
                        end else begin
                            state    <= DONE;
                            dataReg  <= quickRes;
                            validReg <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    prod <= prodNext;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(XLEN - 1)) begin
                        state    <= DONE;
                        dataReg  <= finalRes;
                        validReg <= 1'b1;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state    <= IDLE;
                        validReg <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    validReg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values 8, 16, 32, 64.
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_valid  input  1  request valid.
REQ-005 o_ready  output  1  request ready; high only in IDLE.
REQ-006 i_operandA  input  XLEN  operand A (rs1).
REQ-007 i_operandB  input  XLEN  operand B (rs2/imm).
REQ-008 i_aluOp  input  5  operation select per REQ-012.
REQ-009 i_flush  input  1  abort in-flight/pending operation.
REQ-010 o_valid  output  1  result valid.
REQ-011 i_ready  input  1  result accepted by consumer; o_aluData  output  XLEN  result; o_busy  output  1  high in BUSY.

Function
REQ-012 i_aluOp encoding: 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 XOR, 5 OR, 6 AND, 7 SLL, 8 SRL, 9 SRA, 10 LUI (pass B), 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU; all other codes give result 0 with latency 1.
REQ-013 FSM states IDLE, BUSY, DONE; request accepted when i_valid && o_ready && !i_flush.
REQ-014 Operands and opcode captured at acceptance; input changes afterwards ignored.
REQ-015 Base ops (0-10) and reserved codes: IDLE -> DONE; o_valid high exactly 1 cycle after acceptance edge.
REQ-016 MUL*/DIV*/REM*: IDLE -> BUSY for XLEN cycles (shift-add multiply, restoring divide, one bit per cycle) -> DONE; o_valid high XLEN+1 cycles after acceptance.
REQ-017 All arithmetic modulo 2^XLEN; SUB wraps; SLT signed, SLTU unsigned, result 0 or 1 zero-extended.
REQ-018 Shift amount = low log2(XLEN) bits of operand B; upper bits ignored; SRA sign-fills.
REQ-019 MUL returns low XLEN bits; MULH signed x signed, MULHSU signed A x unsigned B, MULHU unsigned x unsigned, all return high XLEN bits of 2*XLEN product.
REQ-020 Divide by zero: DIV/DIVU = all ones, REM/REMU = operand A; latency 1 (BUSY skipped).
REQ-021 Signed overflow (A = most-negative, B = -1): DIV = A, REM = 0; latency 1.
REQ-022 Signed DIV truncates toward zero; REM sign follows dividend.
REQ-023 DONE: o_valid and o_aluData held stable until i_ready; on o_valid && i_ready -> IDLE next edge, o_valid low.
REQ-024 No new request accepted in BUSY or DONE (o_ready low); back-to-back throughput max one result per 2 cycles.
REQ-025 i_flush high in any state: next edge -> IDLE, o_valid low, o_aluData unchanged; flush wins over same-cycle i_valid and i_ready.
REQ-026 o_busy high exactly while state = BUSY.

Reset
REQ-027 i_rst_n low asynchronously forces IDLE, o_valid 0, o_busy 0, o_aluData 0, internal counters/accumulators 0; o_ready 1 while in IDLE after reset.
REQ-028 Reset mid-BUSY or mid-DONE discards operation; no o_valid after reset release until a new acceptance.

Verification
REQ-029 XLEN=32, ADD 0x7FFFFFFF+1, i_ready=1 -> o_valid 1 cycle later, o_aluData 0x80000000; SUB 10-20 -> 0xFFFFFFF6.
REQ-030 SRA 0x80000000 by B=0x0000003F -> 0xFFFFFFFF (shift 31); SLT 0xFFFFFFFF,0 -> 1; SLTU same -> 0.
REQ-031 MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000 after 33 cycles; MULHU same -> 0xFFFFFFFE; MUL -> 0x00000001.
REQ-032 DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, latency 1; DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7; DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF.
REQ-033 Backpressure: i_ready low 5 cycles after result -> o_valid/o_aluData stable, o_ready low; i_ready high -> IDLE next cycle.
REQ-034 Flush at BUSY cycle 10 of DIVU, then reset pulse during a second MUL -> no o_valid for either; subsequent ADD 15+10 -> 25 with latency 1.
